// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache in front of a 128-bit-block memory.
// A miss writes back a dirty victim, then fills the line and re-runs the lookup as a hit.
module cache_controller #(
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_read_write,
  input  logic [9:0]   cpu_address,
  input  logic [31:0]  cpu_write_data,
  output logic [31:0]  cpu_read_data,
  output logic         cpu_done,
  output logic         mem_read_write,
  output logic [9:0]   mem_address,
  output logic [127:0] mem_write_data,
  input  logic [127:0] mem_read_data
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 6 - IW;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [TW-1:0]  req_tag;
  logic [IW-1:0]  req_idx;
  logic [1:0]     req_word;
  logic           req_wr;
  logic [31:0]    req_wdata;

  logic [NUM_LINES-1:0] valid, dirty;
  logic [TW-1:0]  tag_arr  [NUM_LINES];
  logic [127:0]   data_arr [NUM_LINES];
  logic [CW-1:0]  cnt;

  logic           accept, hit, victim_dirty, cnt_last;
  logic [3:0][31:0] cur_words, wr_words;
  logic           unused_addr_bits;

  logic           done_nxt, mrw_nxt;
  logic [31:0]    rdata_nxt;
  logic [9:0]     maddr_nxt;
  logic [127:0]   mwdata_nxt, line_wdata;
  logic [CW-1:0]  cnt_nxt;
  logic           line_we, tag_we, valid_set, dirty_set, dirty_clr;

  assign unused_addr_bits = ^cpu_address[1:0];
  assign accept       = (state == IDLE) && cpu_req && !cpu_done;
  assign hit          = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim_dirty = valid[req_idx] && dirty[req_idx];
  assign cnt_last     = (cnt == CW'(MEM_LATENCY - 1));
  // Word 0 sits in the top 32 bits, so word k maps to packed slot 3-k (== ~k).
  assign cur_words    = data_arr[req_idx];

  always_comb begin
    wr_words = cur_words;
    wr_words[~req_word] = req_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = COMPARE;
      COMPARE:   state_nxt = hit ? IDLE : (victim_dirty ? WRITEBACK : ALLOCATE);
      WRITEBACK: if (cnt_last) state_nxt = ALLOCATE;
      ALLOCATE:  if (cnt_last) state_nxt = COMPARE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_nxt   = 1'b0;
    rdata_nxt  = cpu_read_data;
    mrw_nxt    = mem_read_write;
    maddr_nxt  = mem_address;
    mwdata_nxt = mem_write_data;
    cnt_nxt    = cnt;
    line_we    = 1'b0;
    line_wdata = cur_words;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    case (state)
      COMPARE: begin
        cnt_nxt = '0;
        if (hit) begin
          done_nxt = 1'b1;
          if (req_wr) begin
            line_we    = 1'b1;
            line_wdata = wr_words;
            dirty_set  = 1'b1;
          end else begin
            rdata_nxt = cur_words[~req_word];
          end
        end else if (victim_dirty) begin
          maddr_nxt  = {tag_arr[req_idx], req_idx, 4'b0000};
          mwdata_nxt = cur_words;
          mrw_nxt    = 1'b1;
        end else begin
          maddr_nxt = {req_tag, req_idx, 4'b0000};
          mrw_nxt   = 1'b0;
        end
      end
      WRITEBACK: begin
        if (cnt_last) begin
          mrw_nxt   = 1'b0;
          maddr_nxt = {req_tag, req_idx, 4'b0000};
          dirty_clr = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ALLOCATE: begin
        if (cnt_last) begin
          line_we    = 1'b1;
          line_wdata = mem_read_data;
          tag_we     = 1'b1;
          valid_set  = 1'b1;
          dirty_clr  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_done       <= 1'b0;
      cpu_read_data  <= '0;
      mem_read_write <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      cnt            <= '0;
      valid          <= '0;
      dirty          <= '0;
      req_tag        <= '0;
      req_idx        <= '0;
      req_word       <= '0;
      req_wr         <= 1'b0;
      req_wdata      <= '0;
    end else begin
      cpu_done       <= done_nxt;
      cpu_read_data  <= rdata_nxt;
      mem_read_write <= mrw_nxt;
      mem_address    <= maddr_nxt;
      mem_write_data <= mwdata_nxt;
      cnt            <= cnt_nxt;
      if (valid_set) valid[req_idx] <= 1'b1;
      if (dirty_set)      dirty[req_idx] <= 1'b1;
      else if (dirty_clr) dirty[req_idx] <= 1'b0;
      if (accept) begin
        req_tag   <= cpu_address[9:4+IW];
        req_idx   <= cpu_address[3+IW:4];
        req_word  <= cpu_address[3:2];
        req_wr    <= cpu_read_write;
        req_wdata <= cpu_write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) data_arr[req_idx] <= line_wdata;
    if (tag_we)  tag_arr[req_idx]  <= req_tag;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench: flat word-memory reference plus per-index occupancy for latency.
module tb_cache_controller;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_read_write;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_done;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;

  cache_controller #(.NUM_LINES(4), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_read_write(cpu_read_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_done(cpu_done),
    .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          lat;
    int          acc;
    logic [9:0]  addr;
  } exp_t;

  exp_t sb[$];

  logic [3:0][31:0] tb_mem [64];
  logic [31:0] ref_words [256];
  logic        m_valid [4];
  logic        m_dirty [4];
  logic [3:0]  m_tag   [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wb_cycles = 0;
  logic [9:0]   last_wb_addr;
  logic [127:0] last_wb_data;
  logic aborted = 1'b0;

  localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB,
                          WC = 32'h3333_CCCC, WD = 32'h4444_DDDD;

  assign mem_read_data = tb_mem[mem_address[9:4]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read_write) tb_mem[mem_address[9:4]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_read_write) begin
      wb_cycles    = wb_cycles + 1;
      last_wb_addr = mem_address;
      last_wb_data = mem_write_data;
    end
  end

  // Completion monitor: every cpu_done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && cpu_done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got cpu_done=1 required no outstanding request (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        if (cyc - e.acc != e.lat) begin
          bad++;
          $display("FAIL latency addr=%h: got %0d cycles required %0d", e.addr, cyc - e.acc, e.lat);
        end
        if (e.is_read) begin
          total++;
          if (cpu_read_data !== e.data) begin
            bad++;
            $display("FAIL read_data addr=%h: got %h required %h", e.addr, cpu_read_data, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic resync_model();
    logic [7:0] wa;
    for (int w = 0; w < 256; w++) begin
      wa = w[7:0];
      ref_words[wa] = tb_mem[wa[7:2]][~wa[1:0]];
    end
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    resync_model();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with cpu_req low for one idle cycle.
  task automatic do_req(input logic rw, input logic [9:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [1:0] idx;
    logic [3:0] tg;
    int n;
    if (aborted) return;
    idx = addr[5:4];
    tg  = addr[9:6];
    e.is_read = !rw;
    e.addr    = addr;
    if (m_valid[idx] && m_tag[idx] == tg) e.lat = 1;
    else if (m_valid[idx] && m_dirty[idx]) e.lat = 2 + 2 * LAT;
    else e.lat = 2 + LAT;
    if (e.lat != 1) m_dirty[idx] = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (rw) begin
      m_dirty[idx] = 1'b1;
      ref_words[addr[9:2]] = wd;
    end
    e.data = ref_words[addr[9:2]];
    e.acc  = cyc + 1;
    sb.push_back(e);
    cpu_req = 1'b1;
    cpu_read_write = rw;
    cpu_address = addr;
    cpu_write_data = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_done && n < 64);
    if (!cpu_done) begin
      total++;
      bad++;
      $display("FAIL timeout addr=%h: got no cpu_done required one within 64 cycles", addr);
      aborted = 1'b1;
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int wb_snap;
    logic [9:0] ra;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_read_write = 1'b0;
    cpu_address = '0;
    cpu_write_data = '0;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) tb_mem[b][k] = $urandom;
    tb_mem[1] = {WA, WB, WC, WD};

    #12;
    check("rst_cpu_done", 128'(cpu_done), 128'(0));
    check("rst_cpu_read_data", 128'(cpu_read_data), 128'(0));
    check("rst_mem_read_write", 128'(mem_read_write), 128'(0));
    check("rst_mem_address", 128'(mem_address), 128'(0));
    check("rst_mem_write_data", mem_write_data, 128'(0));
    @(negedge clk);
    apply_reset();

    do_req(1'b0, 10'h014, '0);
    check("t1_mem_address", 128'(mem_address), 128'h010);
    check("t1_no_writeback", 128'(wb_cycles), 128'(0));

    do_req(1'b0, 10'h018, '0);
    do_req(1'b0, 10'h019, '0);
    check("t2_mem_address_held", 128'(mem_address), 128'h010);

    do_req(1'b1, 10'h018, 32'hDEAD_BEEF);
    do_req(1'b0, 10'h018, '0);
    check("t3_no_writeback", 128'(wb_cycles), 128'(0));

    do_req(1'b0, 10'h118, '0);
    check("t4_wb_cycles", 128'(wb_cycles), 128'(LAT));
    check("t4_wb_addr", 128'(last_wb_addr), 128'h010);
    check("t4_wb_word2", 128'(last_wb_data[63:32]), 128'hDEAD_BEEF);
    check("t4_mem_block", 128'(tb_mem[1][1]), 128'hDEAD_BEEF);
    do_req(1'b0, 10'h110, '0);
    check("t4_fill_addr", 128'(mem_address), 128'h110);

    apply_reset();
    do_req(1'b1, 10'h024, 32'h1234_5678);
    do_req(1'b0, 10'h024, '0);

    apply_reset();
    tb_mem[1] = {WA, WB, WC, WD};
    resync_model();
    do_req(1'b1, 10'h018, 32'hCAFE_F00D);
    wb_snap = wb_cycles;
    cpu_req = 1'b1;
    cpu_read_write = 1'b0;
    cpu_address = 10'h118;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_wb_started", 128'(mem_read_write), 128'(1));
    reset = 1'b1;
    #1;
    check("t6_rw_dropped", 128'(mem_read_write), 128'(0));
    check("t6_no_done", 128'(cpu_done), 128'(0));
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    resync_model();
    @(negedge clk);
    check("t6_wb_not_counted", 128'(wb_cycles), 128'(wb_snap));
    check("t6_mem_untouched", 128'(tb_mem[1][1]), 128'(WC));
    do_req(1'b0, 10'h018, '0);
    check("t6_no_wb_on_refill", 128'(wb_cycles), 128'(wb_snap));

    for (int i = 0; i < 300 && !aborted; i++) begin
      ra = {4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 2'($urandom)};
      do_req(1'($urandom), ra, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: got no completion required end within 1ms");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
